mult_pipe_acc: RTL and testbench
================================

// Module: mult_pipe_acc
// PURPOSE
//  Parametrised, fully pipelined signed/unsigned integer multiplier with optional multiply-accumulate.
//  Next-generation datapath multiplier for the multi-cycle CPU (MULT/MULTU/MADD/MADDU/MSUB/MSUBU).
//  Accepts one operation per cycle under a valid/ready handshake and stalls as a whole on output backpressure.
//  A tag is carried with each operation so the control unit can match results to requests.
// PARAMETERS
//  WIDTH   32  operand width; power of two, 4..64; result is 2*WIDTH bits
//  TAG_W   4   width of the pass-through tag
//  LAT     derived = $clog2(WIDTH)+2; pipeline latency in cycles (7 when WIDTH=32); localparam, not overridable
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  flush      in   1        synchronous kill of all in-flight operations
//  in_valid   in   1        operation request
//  in_ready   out  1        pipeline can accept (= !stall)
//  in_signed  in   1        1: operands two's complement; 0: unsigned
//  in_op      in   2        00 MUL, 01 MADD (acc+p), 10 MSUB (acc-p), 11 reserved (treated as MUL)
//  in_a       in   WIDTH    multiplicand
//  in_b       in   WIDTH    multiplier
//  in_acc     in   2*WIDTH  accumulator operand {HI,LO}; ignored for MUL
//  in_tag     in   TAG_W    tag, returned unchanged with the result
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_z      out  2*WIDTH  result {HI,LO}
//  out_tag    out  TAG_W    tag of the result
//  busy       out  1        any stage holds a valid operation
// BEHAVIOUR
//  Reset: all stage valid bits 0; out_valid=0, out_z=0, out_tag=0, busy=0, in_ready=1.
//  stall = out_valid & ~out_ready. in_ready = ~stall. When stalled, no stage register changes.
//  Accept: on an edge with in_valid & in_ready. Accepting with in_ready=0 is impossible.
//    The bench holds inputs until acceptance.
//  Pipeline per accepted op; each stage carries valid, signed, op, sign, acc and tag alongside the data:
//   S0: magnitudes |a|,|b| (for signed; raw for unsigned).
//     neg = signed & (a[W-1]^b[W-1]).
//     |-2^(W-1)| = 2^(W-1), handled as an unsigned W-bit value.
//   S1: WIDTH partial products, each 2*WIDTH bits, zero-extended: pp[i] = b_mag[i] ? a_mag<<i : 0.
//   S2..S(1+clog2(WIDTH)): binary adder tree, one level per stage, all sums 2*WIDTH bits.
//   Final: p = neg ? -mag : mag (mod 2^(2W)).
//     out_z = MUL: p; MADD: acc+p; MSUB: acc-p (all mod 2^(2W), no overflow flag).
//  Latency: out_valid rises on the LAT-th rising edge after the accepting edge.
//    Back-to-back accepts yield back-to-back results, in order.
//  out_z/out_tag are stable while out_valid & ~out_ready. The result is retired on an edge with out_valid & out_ready.
//  A new result may appear on that same edge, giving a throughput of 1 per cycle.
//  Stall freezes every stage, including bubbles. in_ready drops in the same cycle as stall (combinational).
//  flush (sync): on an edge with flush=1, all valid bits (including out_valid) clear to 0.
//    A same-edge in_valid is discarded. Data registers may keep stale values.
//    flush has priority over stall.
//  busy = OR of all stage valid bits, including out_valid.
//  rst asserted mid-operation: all ops lost immediately, outputs to reset values, no spurious out_valid after release.
//  Width rule: no truncation before the final stage; the accumulate wraps modulo 2^(2*WIDTH).
// TESTING (WIDTH=32)
//  1. MUL unsigned a=0xFFFFFFFF, b=0xFFFFFFFF, tag=3
//     -> out_z=0xFFFFFFFE00000001, out_tag=3, exactly 7 cycles after accept.
//  2. MUL signed a=0x80000000, b=0x80000000 -> 0x4000000000000000.
//     MUL signed a=0xFFFFFFFF(-1), b=5 -> 0xFFFFFFFFFFFFFFFB.
//  3. MADD signed a=-3, b=4, acc=0x0000000000000010 -> 0x0000000000000004.
//     MSUB unsigned a=2, b=3, acc=0 -> 0xFFFFFFFFFFFFFFFA (wrap).
//  4. 10 back-to-back random ops with out_ready=1 -> 10 consecutive valid results, in tag order, each matching the reference model.
//  5. Stream with out_ready held low 5 cycles mid-stream -> in_ready=0 during stall.
//     out_z held constant; no loss or duplication; order preserved.
//  6. flush with 4 ops in flight, then rst pulse mid-stream -> no out_valid for flushed ops; busy=0 next cycle.
//     After rst: all outputs 0, next op latency 7.

Source files
------------

// File: rtl/mult_pipe_acc.sv
// mult_pipe_acc: pipelined signed/unsigned multiplier with MADD/MSUB, tag pass-through.
// Ports: clk, rst, flush, in_* (valid/ready request), out_* (valid/ready result), busy.
module mult_pipe_acc #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2*WIDTH-1:0] in_acc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_z,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int P   = 2 * WIDTH;
  localparam int L   = $clog2(WIDTH);
  localparam int LAT = L + 2;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage valids: [0]=S0, [1]=S1, [2..LAT-1]=adder tree levels.
  logic [LAT-1:0] v_q;
  assign busy = (|v_q) | out_valid;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = in_signed & in_a[WIDTH-1];
  assign b_neg = in_signed & in_b[WIDTH-1];
  // -(-2^(W-1)) wraps back to 2^(W-1), which is the right unsigned magnitude.
  assign a_mag = a_neg ? -in_a : in_a;
  assign b_mag = b_neg ? -in_b : in_b;

  logic [WIDTH-1:0] a_mag_q, b_mag_q;
  // lv_q[0] holds partial products, lv_q[k] holds tree level k.
  logic [P-1:0]     lv_q [L+1][WIDTH];
  logic [LAT-1:0]   neg_q;
  logic [1:0]       op_q  [LAT];
  logic [P-1:0]     acc_q [LAT];
  logic [TAG_W-1:0] tag_q [LAT];

  always_ff @(posedge clk) begin
    if (!stall) begin
      a_mag_q  <= a_mag;
      b_mag_q  <= b_mag;
      neg_q    <= {neg_q[LAT-2:0], a_neg ^ b_neg};
      op_q[0]  <= in_op;
      acc_q[0] <= in_acc;
      tag_q[0] <= in_tag;
      for (int s = 1; s < LAT; s++) begin
        op_q[s]  <= op_q[s-1];
        acc_q[s] <= acc_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        lv_q[0][i] <= b_mag_q[i] ? (P'(a_mag_q) << i) : '0;
      end
      for (int k = 1; k <= L; k++) begin
        for (int j = 0; j < (WIDTH >> k); j++) begin
          lv_q[k][j] <= lv_q[k-1][2*j] + lv_q[k-1][2*j+1];
        end
        for (int j = (WIDTH >> k); j < WIDTH; j++) begin
          lv_q[k][j] <= '0;
        end
      end
    end
  end

  logic [P-1:0] mag, prod, z_fin;
  logic [1:0]   op_l;
  logic [P-1:0] acc_l;

  always_comb begin
    mag   = lv_q[L][0];
    op_l  = op_q[LAT-1];
    acc_l = acc_q[LAT-1];
    prod  = neg_q[LAT-1] ? -mag : mag;
    z_fin = prod;
    unique case (1'b1)
      op_l == 2'b01: z_fin = acc_l + prod;
      op_l == 2'b10: z_fin = acc_l - prod;
      default:       z_fin = prod;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      v_q       <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      v_q       <= {v_q[LAT-2:0], in_valid};
      out_valid <= v_q[LAT-1];
      if (v_q[LAT-1]) begin
        out_z   <= z_fin;
        out_tag <= tag_q[LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe_acc.sv
// tb_mult_pipe_acc: directed + random checks of mult_pipe_acc (WIDTH=32)
// against an arithmetic reference model and an in-order scoreboard.
module tb_mult_pipe_acc;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, in_signed;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [63:0] in_acc;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_z;
  logic [3:0]  out_tag;
  logic        busy;

  always #5 clk = ~clk;

  mult_pipe_acc #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_tag(out_tag), .busy(busy)
  );

  typedef struct {
    logic [63:0] z;
    logic [3:0]  tag;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  bit          last_acc;
  bit          held_vld;
  logic [63:0] held_z;
  int          ret_cnt, ret_first, ret_last;

  function automatic logic [63:0] model(logic sgn, logic [1:0] op,
                                        logic [31:0] a, logic [31:0] b,
                                        logic [63:0] acc);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    if (sgn) p = sa * sb;
    else     p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b01:   return acc + p;
      2'b10:   return acc - p;
      default: return p;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Samples handshakes just before the edge, then advances to next negedge.
  task automatic step();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (flush) begin
      q.delete();
      held_vld = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("result_z", out_z, e.z);
          chk("result_tag", {60'd0, out_tag}, {60'd0, e.tag});
          if (ret_cnt == 0) ret_first = cyc;
          ret_last = cyc;
          ret_cnt++;
        end
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        if (held_vld) chk("stall_hold_z", out_z, held_z);
        held_z   = out_z;
        held_vld = 1'b1;
      end else begin
        held_vld = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.z   = model(in_signed, in_op, in_a, in_b, in_acc);
        e.tag = in_tag;
        q.push_back(e);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue();
    int n = 0;
    in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 50);
    in_valid = 1'b0;
    if (!last_acc) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic single(string nm, logic sgn, logic [1:0] op,
                        logic [31:0] a, logic [31:0] b,
                        logic [63:0] acc, logic [3:0] tag,
                        logic [63:0] exp);
    int k = 0;
    in_signed = sgn;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_acc    = acc;
    in_tag    = tag;
    issue();
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk({nm, "_latency"}, 64'(k), 64'd7);
    chk({nm, "_z"}, out_z, exp);
    chk({nm, "_tag"}, {60'd0, out_tag}, {60'd0, tag});
    step();
  endtask

  task automatic rand_in(int t);
    in_signed = 1'($urandom_range(0, 1));
    in_op     = 2'($urandom_range(0, 3));
    in_a      = $urandom;
    in_b      = $urandom;
    in_acc    = {$urandom, $urandom};
    in_tag    = 4'(t);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    in_acc    = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    held_vld  = 1'b0;
    ret_cnt   = 0;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_z", out_z, 64'd0);
    chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    single("t1_umax", 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'd0, 4'd3, 64'hFFFFFFFE00000001);
    single("t2_smin", 1'b1, 2'b00, 32'h80000000, 32'h80000000,
           64'd0, 4'd4, 64'h4000000000000000);
    single("t2_sneg", 1'b1, 2'b00, 32'hFFFFFFFF, 32'd5,
           64'd0, 4'd5, 64'hFFFFFFFFFFFFFFFB);
    single("t3_madd", 1'b1, 2'b01, 32'hFFFFFFFD, 32'd4,
           64'h10, 4'd6, 64'h4);
    single("t3_msub", 1'b0, 2'b10, 32'd2, 32'd3,
           64'd0, 4'd7, 64'hFFFFFFFFFFFFFFFA);
    single("t3_rsvd", 1'b1, 2'b11, 32'hFFFFFFFE, 32'd7,
           64'h1234, 4'd8, 64'hFFFFFFFFFFFFFFF2);

    // Back-to-back random stream, no backpressure.
    ret_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      rand_in(i);
      in_valid = 1'b1;
      step();
      chk("t4_accept", {63'd0, last_acc}, 64'd1);
    end
    in_valid = 1'b0;
    drain();
    chk("t4_count", 64'(ret_cnt), 64'd10);
    chk("t4_consecutive", 64'(ret_last - ret_first), 64'd9);

    // Stream with a 5-cycle output stall in the middle.
    sent = 0;
    rand_in(0);
    in_valid = 1'b1;
    for (int c = 0; c < 200 && (sent < 12 || q.size() != 0); c++) begin
      out_ready = !(c >= 9 && c < 14);
      step();
      if (last_acc) begin
        sent++;
        if (sent < 12) rand_in(sent);
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_sent", 64'(sent), 64'd12);
    chk("t5_queue_empty", 64'(q.size()), 64'd0);

    // Flush with four ops in flight plus a same-edge request.
    for (int i = 0; i < 4; i++) begin
      rand_in(i);
      in_valid = 1'b1;
      step();
    end
    rand_in(4);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t6_flush_busy", {63'd0, busy}, 64'd0);
    chk("t6_flush_valid", {63'd0, out_valid}, 64'd0);
    repeat (12) step();
    chk("t6_post_flush_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      rand_in(i + 9);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_z", out_z, 64'd0);
    chk("t6_rst_tag", {60'd0, out_tag}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    held_vld = 1'b0;
    repeat (10) step();
    chk("t6_post_rst_valid", {63'd0, out_valid}, 64'd0);
    single("t6_after_rst", 1'b0, 2'b01, 32'd1000, 32'd3000,
           64'd7, 4'd9, 64'd3000007);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
